// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - request, response and word-memory bus of the sub-word access controller
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3, mem_rd,
    input  req_ready, resp_valid, resp_err, resp_rdata, mem_we, mem_a, mem_wd
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3, mem_rd,
    output req_ready, resp_valid, resp_err, resp_rdata, mem_we, mem_a, mem_wd
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - byte/halfword/word load-store controller over a word-only synchronous memory
module mem_access_ctrl (
  input logic              clk,
  input logic              rst,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, LD_RD, LD_RESP, ST_WR, RMW_RD, RMW_WR, ERR
  } state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  funct3_q;

  logic        illegal;
  logic        misaligned;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_data;
  logic [31:0] merged;
  logic        mem_we_w;

  always_comb begin
    illegal    = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                 (bus.req_funct3 == 3'b111) || (bus.req_funct3[2] && bus.req_we);
    misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                 ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      funct3_q <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            funct3_q <= bus.req_funct3;
            if (illegal || misaligned)             state <= ERR;
            else if (!bus.req_we)                  state <= LD_RD;
            else if (bus.req_funct3[1:0] == 2'b10) state <= ST_WR;
            else                                   state <= RMW_RD;
          end
        end
        LD_RD:   state <= LD_RESP;
        RMW_RD:  state <= RMW_WR;
        default: state <= IDLE;
      endcase
    end
  end

  // Lane selection and merge both work on mem_rd, which is valid in LD_RESP / RMW_WR.
  always_comb begin
    case (addr_q[1:0])
      2'b00:   byte_lane = bus.mem_rd[7:0];
      2'b01:   byte_lane = bus.mem_rd[15:8];
      2'b10:   byte_lane = bus.mem_rd[23:16];
      default: byte_lane = bus.mem_rd[31:24];
    endcase
    half_lane = addr_q[1] ? bus.mem_rd[31:16] : bus.mem_rd[15:0];

    case (funct3_q)
      3'b000:  load_data = {{24{byte_lane[7]}}, byte_lane};
      3'b001:  load_data = {{16{half_lane[15]}}, half_lane};
      3'b100:  load_data = {24'd0, byte_lane};
      3'b101:  load_data = {16'd0, half_lane};
      default: load_data = bus.mem_rd;
    endcase

    merged = bus.mem_rd;
    if (!funct3_q[0]) begin
      case (addr_q[1:0])
        2'b00:   merged[7:0]   = wdata_q[7:0];
        2'b01:   merged[15:8]  = wdata_q[7:0];
        2'b10:   merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  // Reset gates the strobes combinationally so a reset cycle never writes or responds.
  assign mem_we_w       = !rst && ((state == ST_WR) || (state == RMW_WR));
  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = !rst && ((state == LD_RESP) || (state == ST_WR) ||
                                   (state == RMW_WR) || (state == ERR));
  assign bus.resp_err   = !rst && (state == ERR);
  assign bus.resp_rdata = (!rst && (state == LD_RESP)) ? load_data : 32'd0;
  assign bus.mem_we     = mem_we_w;
  assign bus.mem_a      = (state == IDLE) ? 32'd0 : {addr_q[31:2], 2'b00};
  assign bus.mem_wd     = !mem_we_w ? 32'd0 : ((state == ST_WR) ? wdata_q : merged);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl
module tb_mem_access_ctrl;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_resp = 0;

  mem_access_ctrl_if bus ();

  mem_access_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem    [16];
  logic [31:0] shadow [16];

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  typedef struct {
    int          due;
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  resp_t rq[$];
  wr_t   wq[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_a[5:2]] <= bus.mem_wd;
    bus.mem_rd <= mem[bus.mem_a[5:2]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [31:0] a,
                                           input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[a[1:0]*8 +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  // Response and memory-write scoreboards, sampled mid-low-phase.
  initial begin
    resp_t e;
    wr_t   w;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (bus.resp_valid) begin
          n_resp++;
          if (rq.size() == 0) check("unexpected_resp", bus.resp_valid, 1'b0);
          else begin
            e = rq.pop_front();
            check("resp_cycle", cyc, e.due);
            check("resp_err", bus.resp_err, e.err);
            check("resp_rdata", bus.resp_rdata, e.rdata);
          end
        end
        if (bus.mem_we) begin
          if (wq.size() == 0) check("unexpected_mem_we", bus.mem_we, 1'b0);
          else begin
            w = wq.pop_front();
            check("wr_cycle", cyc, w.due);
            check("wr_addr", bus.mem_a, w.a);
            check("wr_data", bus.mem_wd, w.d);
          end
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] f3, input bit hold, input bit use_exp,
                       input logic [31:0] exp_rd, output int acc);
    int          n;
    bit          bad;
    logic [31:0] w;
    bus.req_we     = we;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_funct3 = f3;
    bus.req_valid  = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      check("ready_timeout", bus.req_ready, 1'b1);
      bus.req_valid = 1'b0;
      acc = -1;
      return;
    end
    @(negedge clk);
    acc = cyc;
    bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (f3[2] && we) ||
          ((f3[1:0] == 2'b01) && addr[0]) || ((f3 == 3'b010) && (addr[1:0] != 2'b00));
    if (bad) begin
      rq.push_back('{acc, 1'b1, 32'd0});
    end else if (!we) begin
      rq.push_back('{acc + 1, 1'b0, use_exp ? exp_rd : exp_load(shadow[addr[5:2]], addr, f3)});
    end else if (f3 == 3'b010) begin
      rq.push_back('{acc, 1'b0, 32'd0});
      wq.push_back('{acc, {addr[31:2], 2'b00}, wdata});
      shadow[addr[5:2]] = wdata;
    end else begin
      w = shadow[addr[5:2]];
      if (f3 == 3'b000) w[addr[1:0]*8 +: 8] = wdata[7:0];
      else              w[addr[1]*16 +: 16] = wdata[15:0];
      rq.push_back('{acc + 1, 1'b0, 32'd0});
      wq.push_back('{acc + 1, {addr[31:2], 2'b00}, w});
      shadow[addr[5:2]] = w;
    end
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rq.size() != 0 || wq.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_resp_queue", rq.size(), 0);
    check("drain_wr_queue", wq.size(), 0);
  endtask

  initial begin
    int acc;
    int acc1;
    int acc2;
    int resp_before;
    for (int i = 0; i < 16; i++) begin
      mem[i]    = 32'h1111_1111 * i + 32'h0102_0304;
      shadow[i] = mem[i];
    end
    mem[1]    = 32'h8899AABB;
    shadow[1] = 32'h8899AABB;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.req_funct3 = 3'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_req_ready", bus.req_ready, 1'b1);
    check("rst_resp_valid", bus.resp_valid, 1'b0);
    check("rst_resp_err", bus.resp_err, 1'b0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_mem_we", bus.mem_we, 1'b0);
    check("rst_mem_a", bus.mem_a, 32'd0);
    check("rst_mem_wd", bus.mem_wd, 32'd0);
    @(negedge clk);

    issue(1'b0, 32'h7, 32'd0, 3'b000, 0, 1, 32'hFFFFFF88, acc);
    issue(1'b0, 32'h7, 32'd0, 3'b100, 0, 1, 32'h00000088, acc);
    issue(1'b0, 32'h4, 32'd0, 3'b001, 0, 1, 32'hFFFFAABB, acc);
    issue(1'b0, 32'h6, 32'd0, 3'b101, 0, 1, 32'h00008899, acc);
    issue(1'b1, 32'h5, 32'h123456CC, 3'b000, 0, 0, 32'd0, acc);
    issue(1'b0, 32'h4, 32'd0, 3'b010, 0, 1, 32'h8899CCBB, acc);
    issue(1'b1, 32'h8, 32'hDEADBEEF, 3'b010, 0, 0, 32'd0, acc);
    issue(1'b0, 32'h8, 32'd0, 3'b010, 0, 1, 32'hDEADBEEF, acc);
    issue(1'b0, 32'h3, 32'd0, 3'b001, 0, 0, 32'd0, acc);
    issue(1'b0, 32'h4, 32'd0, 3'b111, 0, 0, 32'd0, acc);
    issue(1'b1, 32'h4, 32'd0, 3'b100, 0, 0, 32'd0, acc);
    issue(1'b1, 32'h6, 32'h0000BEAD, 3'b001, 0, 0, 32'd0, acc);
    issue(1'b0, 32'h4, 32'd0, 3'b010, 0, 1, 32'hBEADCCBB, acc);
    drain();

    // Reset landing in RMW_WR of a byte store.
    bus.req_we     = 1'b1;
    bus.req_addr   = 32'h5;
    bus.req_wdata  = 32'h000000EE;
    bus.req_funct3 = 3'b000;
    bus.req_valid  = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_rmw_mem_we", bus.mem_we, 1'b0);
    check("rst_rmw_resp_valid", bus.resp_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_rmw_ready", bus.req_ready, 1'b1);
    check("rst_rmw_resp_after", bus.resp_valid, 1'b0);
    check("rst_rmw_mem_word", mem[1], shadow[1]);
    @(negedge clk);

    resp_before = n_resp;
    issue(1'b0, 32'h4, 32'd0, 3'b010, 1, 0, 32'd0, acc1);
    issue(1'b0, 32'h8, 32'd0, 3'b010, 0, 0, 32'd0, acc2);
    check("b2b_second_accept", acc2, acc1 + 3);
    drain();
    check("b2b_resp_count", n_resp - resp_before, 2);

    for (int i = 0; i < 30; i++) begin
      issue(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom,
            3'($urandom_range(0, 7)), 0, 0, 32'd0, acc);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
